// File: rtl/sixteen_bit_nibble_adder.sv
// Serial 16-bit adder: one 4-bit ripple slice reused over four cycles, LSB nibble first.
// A result is presented for exactly one cycle (done) before returning to IDLE or restarting.
module sixteen_bit_nibble_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Ovf,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_carry;
  logic [1:0]  r_idx;
  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_ovf;

  logic [3:0]  w_a_nib [4];
  logic [3:0]  w_b_nib [4];
  logic [3:0]  w_op_a;
  logic [3:0]  w_op_b;
  logic [3:0]  w_slice_sum;
  logic [4:0]  w_chain;
  logic        w_accept;
  logic        w_last;
  logic        w_ovf;

  genvar gi;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign w_a_nib[gi] = r_a[4*gi +: 4];
      assign w_b_nib[gi] = r_b[4*gi +: 4];
    end
  endgenerate

  assign w_op_a = w_a_nib[r_idx];
  assign w_op_b = w_b_nib[r_idx];

  // 4-bit ripple slice; its carry-in is the carry left by the previous nibble
  assign w_chain[0] = r_carry;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign w_slice_sum[gi] = w_op_a[gi] ^ w_op_b[gi] ^ w_chain[gi];
      assign w_chain[gi+1]   = (w_op_a[gi] & w_op_b[gi]) |
                               (w_chain[gi] & (w_op_a[gi] ^ w_op_b[gi]));
    end
  endgenerate

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_idx == 2'd3);
  // Slice bit 3 on the last nibble is the final Sum[15]
  assign w_ovf    = (r_a[15] == r_b[15]) && (w_slice_sum[3] != r_a[15]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= start ? S_RUN : S_IDLE;
        S_RUN:   r_state <= w_last ? S_DONE : S_RUN;
        S_DONE:  r_state <= start ? S_RUN : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_carry <= 1'b0;
      r_idx   <= 2'd0;
      r_sum   <= 16'h0000;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= 2'd0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
      r_carry <= w_chain[4];
      r_idx   <= r_idx + 2'd1;
      if (w_last) begin
        r_cout <= w_chain[4];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule
